dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory between requester A (CPU MEM stage) and requester B (DMA/debug loader).
- Round-robin grant with a valid/ready request handshake.
- A registered command stage drives the memory. Each requester gets a one-cycle-latency response.
- Sits between the pipeline/DMA and the data memory. It drives the memory's write-enable, address and write-data, and consumes its combinational read data.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data memory. Used only for range checking.
- ADDR_W, 32, byte-address width of request and memory address ports.

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- A_Req_Valid  in  1  requester A has a request
- A_Req_Ready  out  1  A request accepted this cycle when Valid&Ready
- A_Req_Write  in  1  1=write, 0=read
- A_Req_Address  in  ADDR_W  byte address
- A_Req_Write_Data  in  32  store data
- A_Rsp_Valid  out  1  response for A this cycle
- A_Rsp_Read_Data  out  32  load data (0 for writes)
- A_Rsp_Error  out  1  access rejected (see Optional Feature)
- B_Req_Valid, B_Req_Ready, B_Req_Write, B_Req_Address, B_Req_Write_Data, B_Rsp_Valid, B_Rsp_Read_Data, B_Rsp_Error: same as A, for requester B
- Mem_Write  out  1  memory write enable
- Mem_Address  out  ADDR_W  byte address to memory (memory uses bits [ADDR_W-1:2])
- Mem_Write_Data  out  32  memory write data
- Mem_Read_Data  in  32  combinational read data from memory

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low on Reset_n; all state is cleared immediately on assertion.
- Reset values:
  - Cmd_Valid=0, Last_Grant=B.
  - All Rsp_Valid=0, Rsp_Read_Data=0, Rsp_Error=0.
  - Mem_Write=0, Mem_Address=0, Mem_Write_Data=0.
- Arbitration (combinational, every cycle):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester not equal to Last_Grant.
  - Neither valid: no grant.
- Ready and acceptance:
  - X_Req_Ready = grant_X. Ready is never asserted for a requester whose Valid is low.
  - The arbiter accepts at most one request per cycle.
  - On acceptance, Last_Grant <= X.
- Command register, loaded on acceptance: Cmd_Valid<=1, plus Cmd_Id, Cmd_Write, Cmd_Addr, Cmd_Data. Otherwise Cmd_Valid<=0.
- Memory drive, in cycle N+1 after acceptance in cycle N:
  - Mem_Address = Cmd_Addr.
  - Mem_Write_Data = Cmd_Data.
  - Mem_Write = Cmd_Valid & Cmd_Write & ~Cmd_Err.
  - When Cmd_Valid=0: Mem_Write=0. Address and data hold their last value.
- Response, in cycle N+1 (combinational from the command register):
  - X_Rsp_Valid = Cmd_Valid & (Cmd_Id==X).
  - X_Rsp_Read_Data = Mem_Read_Data for a read without error, otherwise 0.
  - X_Rsp_Error = Cmd_Err.
  - Latency is 1 cycle. Throughput is 1 access per cycle. There is no response back-pressure; requesters must sink responses.
- Write-then-read of the same address on consecutive cycles:
  - The write commits at the end of cycle N+1.
  - The read issued in cycle N+1 observes the new data in cycle N+2.
- Requester obligations:
  - A requester must hold Valid and request fields stable until Ready.
  - The arbiter does not check this.
- Reset mid-operation:
  - An in-flight command is dropped: no memory write, no response.
  - Last_Grant returns to B, so A wins the first tie after reset.
- Fairness: under continuous contention, grants alternate A,B,A,B. No requester waits more than 1 cycle.

Optional Feature:
- Macro: DMEM_ARB_ADDR_CHECK_EN.
- When defined:
  - Cmd_Err is computed at acceptance and registered.
  - Cmd_Err=1 if Address[1:0]!=0, or if word index Address[ADDR_W-1:2] >= DEPTH.
  - An erroring write does not assert Mem_Write.
  - An erroring read returns Rsp_Read_Data=0.
  - In both cases Rsp_Error=1 alongside Rsp_Valid.
- When undefined:
  - Cmd_Err is constant 0 and Rsp_Error outputs are tied 0.
  - Address bits [1:0] are ignored and passed through.
  - Out-of-range indices go to the memory unchecked.

Test Plan:
- Reset, then A writes 0xDEADBEEF to 0x10 (B idle) -> A_Req_Ready=1 in cycle 0; cycle 1: Mem_Write=1, Mem_Address=0x10, A_Rsp_Valid=1, A_Rsp_Read_Data=0. Then A reads 0x10 -> next cycle A_Rsp_Read_Data=0xDEADBEEF.
- A and B both valid every cycle for 6 cycles after reset -> grants A,B,A,B,A,B. Each response arrives 1 cycle after its grant on the matching port only.
- B writes 0x55 to 0x20 in cycle 0, B reads 0x20 in cycle 1 -> cycle 2 B_Rsp_Read_Data=0x55. Back-to-back throughput with no bubble.
- Reset_n pulsed low while Cmd_Valid=1 (pending write of 0x1234 to 0x40) -> no Mem_Write. A subsequent read of 0x40 returns the prior content. The next A/B tie grants A.
- With DMEM_ARB_ADDR_CHECK_EN: A writes to 0x1002 (misaligned) and reads 0x1000 (index 1024 >= DEPTH) -> Mem_Write=0. Both responses have A_Rsp_Error=1 and Rsp_Read_Data=0.
- Without the macro, same accesses -> A_Rsp_Error=0. The write asserts Mem_Write with Mem_Address=0x1002.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between requester A (CPU MEM stage) and
// requester B (DMA / debug loader). Requests use a valid/ready handshake and
// are granted round-robin. An accepted request is captured in a command
// register that drives the memory in the following cycle. The response is
// formed combinationally from that register and the memory's combinational
// read data, which gives one cycle of latency and one access per cycle.
//
// Parameters
//   DEPTH   number of 32-bit words in the data memory (range check only)
//   ADDR_W  byte-address width of request and memory address ports
//
// Ports
//   Clk, Reset_n                 clock, asynchronous active-low reset
//   A_Req_* / B_Req_*            request channel (Valid, Ready, Write,
//                                Address, Write_Data)
//   A_Rsp_* / B_Rsp_*            response channel (Valid, Read_Data, Error)
//   Mem_Write, Mem_Address,
//   Mem_Write_Data               registered memory command
//   Mem_Read_Data                combinational read data from memory
//
// Optional feature
//   DMEM_ARB_ADDR_CHECK_EN  when defined, misaligned or out-of-range
//                           accesses are rejected: no memory write, zero
//                           read data, Rsp_Error raised with Rsp_Valid.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,

    input  logic              A_Req_Valid,
    output logic              A_Req_Ready,
    input  logic              A_Req_Write,
    input  logic [ADDR_W-1:0] A_Req_Address,
    input  logic [31:0]       A_Req_Write_Data,
    output logic              A_Rsp_Valid,
    output logic [31:0]       A_Rsp_Read_Data,
    output logic              A_Rsp_Error,

    input  logic              B_Req_Valid,
    output logic              B_Req_Ready,
    input  logic              B_Req_Write,
    input  logic [ADDR_W-1:0] B_Req_Address,
    input  logic [31:0]       B_Req_Write_Data,
    output logic              B_Rsp_Valid,
    output logic [31:0]       B_Rsp_Read_Data,
    output logic              B_Rsp_Error,

    output logic              Mem_Write,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [31:0]       Mem_Write_Data,
    input  logic [31:0]       Mem_Read_Data
);

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // The address needs at least two byte-offset bits plus one index bit.
    if (ADDR_W < 3 || DEPTH < 1) begin : g_param_check
        $error("dmem_arbiter: ADDR_W must be >= 3 and DEPTH >= 1");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    req_id_t             last_grant_reg;
    logic                cmd_valid_reg;
    req_id_t             cmd_id_reg;
    logic                cmd_write_reg;
    logic [ADDR_W-1:0]   cmd_addr_reg;
    logic [31:0]         cmd_data_reg;
    logic                cmd_err;

    // -------------------------------------------------------------------------
    // Round-robin arbitration: a tie goes to whoever did not win last time.
    // -------------------------------------------------------------------------
    logic grant_a;
    logic grant_b;
    logic accept;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (A_Req_Valid && B_Req_Valid) begin
            if (last_grant_reg == REQ_B) begin
                grant_a = 1'b1;
            end else begin
                grant_b = 1'b1;
            end
        end else begin
            grant_a = A_Req_Valid;
            grant_b = B_Req_Valid;
        end
    end

    assign accept      = grant_a | grant_b;
    assign A_Req_Ready = grant_a;
    assign B_Req_Ready = grant_b;

    // Fields of the winning request
    logic                req_write;
    logic [ADDR_W-1:0]   req_addr;
    logic [31:0]         req_data;

    always_comb begin
        req_write = A_Req_Write;
        req_addr  = A_Req_Address;
        req_data  = A_Req_Write_Data;
        if (grant_b) begin
            req_write = B_Req_Write;
            req_addr  = B_Req_Address;
            req_data  = B_Req_Write_Data;
        end
    end

    // -------------------------------------------------------------------------
    // Address check, evaluated at acceptance so the error is ready alongside
    // the command in the memory cycle.
    // -------------------------------------------------------------------------
`ifdef DMEM_ARB_ADDR_CHECK_EN
    logic              req_err;
    logic [ADDR_W-1:0] req_word_idx;
    logic              cmd_err_reg;

    always_comb begin
        req_word_idx = {2'b00, req_addr[ADDR_W-1:2]};
        req_err      = (req_addr[1:0] != 2'b00) ||
                       (req_word_idx >= ADDR_W'(DEPTH));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cmd_err_reg <= 1'b0;
        end else if (accept) begin
            cmd_err_reg <= req_err;
        end
    end

    assign cmd_err = cmd_err_reg;
`else
    assign cmd_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Command register. Address and data only load on acceptance so the
    // memory-side bus holds its last value while idle.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_grant_reg <= REQ_B;
            cmd_valid_reg  <= 1'b0;
            cmd_id_reg     <= REQ_A;
            cmd_write_reg  <= 1'b0;
            cmd_addr_reg   <= '0;
            cmd_data_reg   <= '0;
        end else begin
            cmd_valid_reg <= accept;
            if (accept) begin
                last_grant_reg <= grant_b ? REQ_B : REQ_A;
                cmd_id_reg     <= grant_b ? REQ_B : REQ_A;
                cmd_write_reg  <= req_write;
                cmd_addr_reg   <= req_addr;
                cmd_data_reg   <= req_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Memory drive
    // -------------------------------------------------------------------------
    assign Mem_Write      = cmd_valid_reg & cmd_write_reg & ~cmd_err;
    assign Mem_Address    = cmd_addr_reg;
    assign Mem_Write_Data = cmd_data_reg;

    // -------------------------------------------------------------------------
    // Responses: index 0 is requester A, index 1 is requester B.
    // -------------------------------------------------------------------------
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_error;
    logic [31:0] rsp_read_data [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rsp_valid[gi]     = cmd_valid_reg &&
                                   (cmd_id_reg == ((gi == 0) ? REQ_A : REQ_B));
        // Writes and rejected reads return zero so stale memory data never
        // leaks onto a response.
        assign rsp_read_data[gi] = (rsp_valid[gi] && !cmd_write_reg && !cmd_err)
                                   ? Mem_Read_Data : 32'h0;
        assign rsp_error[gi]     = rsp_valid[gi] & cmd_err;
    end

    assign A_Rsp_Valid     = rsp_valid[0];
    assign A_Rsp_Read_Data = rsp_read_data[0];
    assign A_Rsp_Error     = rsp_error[0];
    assign B_Rsp_Valid     = rsp_valid[1];
    assign B_Rsp_Read_Data = rsp_read_data[1];
    assign B_Rsp_Error     = rsp_error[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives both requesters of dmem_arbiter, emulates the data memory with a
// combinational-read array, and compares every cycle against a transaction
// level reference model (expected memory image, last winner, in-flight
// command). Inputs change 1 time unit after the rising edge; outputs are
// sampled 1 time unit later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int DEPTH     = 1024;
    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 2048;

    logic              Clk;
    logic              Reset_n;
    logic              A_Req_Valid, A_Req_Ready, A_Req_Write;
    logic [ADDR_W-1:0] A_Req_Address;
    logic [31:0]       A_Req_Write_Data;
    logic              A_Rsp_Valid, A_Rsp_Error;
    logic [31:0]       A_Rsp_Read_Data;
    logic              B_Req_Valid, B_Req_Ready, B_Req_Write;
    logic [ADDR_W-1:0] B_Req_Address;
    logic [31:0]       B_Req_Write_Data;
    logic              B_Rsp_Valid, B_Rsp_Error;
    logic [31:0]       B_Rsp_Read_Data;
    logic              Mem_Write;
    logic [ADDR_W-1:0] Mem_Address;
    logic [31:0]       Mem_Write_Data;
    logic [31:0]       Mem_Read_Data;

    dmem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .A_Req_Valid(A_Req_Valid), .A_Req_Ready(A_Req_Ready),
        .A_Req_Write(A_Req_Write), .A_Req_Address(A_Req_Address),
        .A_Req_Write_Data(A_Req_Write_Data), .A_Rsp_Valid(A_Rsp_Valid),
        .A_Rsp_Read_Data(A_Rsp_Read_Data), .A_Rsp_Error(A_Rsp_Error),
        .B_Req_Valid(B_Req_Valid), .B_Req_Ready(B_Req_Ready),
        .B_Req_Write(B_Req_Write), .B_Req_Address(B_Req_Address),
        .B_Req_Write_Data(B_Req_Write_Data), .B_Rsp_Valid(B_Rsp_Valid),
        .B_Rsp_Read_Data(B_Rsp_Read_Data), .B_Rsp_Error(B_Rsp_Error),
        .Mem_Write(Mem_Write), .Mem_Address(Mem_Address),
        .Mem_Write_Data(Mem_Write_Data), .Mem_Read_Data(Mem_Read_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Power-on content of every memory word
    function automatic logic [31:0] init_word(input int idx);
        return 32'hA5A5_0000 ^ (idx * 32'h0000_9E37);
    endfunction

    // ---------------- memory emulation (the DUT's environment) --------------
    logic [31:0] mem_q       [MEM_WORDS];
    bit          mem_written [MEM_WORDS];
    logic [10:0] mem_idx;

    assign mem_idx       = Mem_Address[12:2];
    assign Mem_Read_Data = mem_written[mem_idx] ? mem_q[mem_idx] : init_word(int'(mem_idx));

    always @(posedge Clk) begin
        if (Mem_Write) begin
            mem_q[mem_idx]       <= Mem_Write_Data;
            mem_written[mem_idx] <= 1'b1;
        end
    end

    // ---------------- reference model ---------------------------------------
    logic [31:0] model_mem [MEM_WORDS];
    int          model_last;          // 0 = A won last, 1 = B won last
    bit          pend_v, pend_w, pend_err;
    int          pend_id;
    logic [31:0] pend_addr, pend_data;
    logic [31:0] last_acc_addr, last_acc_data;
    int          cur_grant;           // -1 none, 0 A, 1 B

    bit          exp_a_ready, exp_b_ready, exp_a_rv, exp_b_rv;
    bit          exp_a_err, exp_b_err, exp_mw;
    logic [31:0] exp_a_rd, exp_b_rd, exp_maddr, exp_mwd;

    function automatic bit addr_err(input logic [31:0] a);
`ifdef DMEM_ARB_ADDR_CHECK_EN
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    task automatic model_reset();
        pend_v        = 1'b0;
        pend_w        = 1'b0;
        pend_err      = 1'b0;
        pend_id       = 0;
        model_last    = 1;
        last_acc_addr = 32'h0;
        last_acc_data = 32'h0;
    endtask

    // Expected outputs for the current cycle, given the inputs now driven.
    task automatic model_eval();
        logic [31:0] rd;
        if (A_Req_Valid && B_Req_Valid) cur_grant = (model_last == 1) ? 0 : 1;
        else if (A_Req_Valid)           cur_grant = 0;
        else if (B_Req_Valid)           cur_grant = 1;
        else                            cur_grant = -1;
        exp_a_ready = (cur_grant == 0);
        exp_b_ready = (cur_grant == 1);
        exp_a_rv    = pend_v && (pend_id == 0);
        exp_b_rv    = pend_v && (pend_id == 1);
        rd          = (pend_v && !pend_w && !pend_err) ? model_mem[pend_addr[12:2]] : 32'h0;
        exp_a_rd    = exp_a_rv ? rd : 32'h0;
        exp_b_rd    = exp_b_rv ? rd : 32'h0;
        exp_a_err   = exp_a_rv && pend_err;
        exp_b_err   = exp_b_rv && pend_err;
        exp_mw      = pend_v && pend_w && !pend_err;
        exp_maddr   = last_acc_addr;
        exp_mwd     = last_acc_data;
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_commit();
        if (exp_mw) model_mem[pend_addr[12:2]] = pend_data;
        pend_v = (cur_grant >= 0);
        if (cur_grant >= 0) begin
            pend_id       = cur_grant;
            pend_w        = (cur_grant == 0) ? A_Req_Write      : B_Req_Write;
            pend_addr     = (cur_grant == 0) ? A_Req_Address    : B_Req_Address;
            pend_data     = (cur_grant == 0) ? A_Req_Write_Data : B_Req_Write_Data;
            pend_err      = addr_err(pend_addr);
            model_last    = cur_grant;
            last_acc_addr = pend_addr;
            last_acc_data = pend_data;
            $display("[TB] accept %s %s addr=%08h data=%08h", (cur_grant == 0) ? "A" : "B",
                     pend_w ? "WR" : "RD", pend_addr, pend_data);
        end
    endtask

    function automatic logic [6:0] exp_ctl();
        return {exp_a_ready, exp_b_ready, exp_a_rv, exp_b_rv, exp_a_err, exp_b_err, exp_mw};
    endfunction

    function automatic logic [6:0] obs_ctl();
        return {A_Req_Ready, B_Req_Ready, A_Rsp_Valid, B_Rsp_Valid, A_Rsp_Error, B_Rsp_Error, Mem_Write};
    endfunction

    // ---------------- stimulus helpers (no checking) -------------------------
    task automatic drive(input logic av, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                         input logic bv, input logic bw, input logic [31:0] ba, input logic [31:0] bd);
        A_Req_Valid = av; A_Req_Write = aw; A_Req_Address = aa; A_Req_Write_Data = ad;
        B_Req_Valid = bv; B_Req_Write = bw; B_Req_Address = ba; B_Req_Write_Data = bd;
    endtask

    // Leaves the bench 1 unit after a rising edge with reset released.
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        Reset_n = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ---------------------------------------------------
    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        tests_run++;
        if (obs_ctl() !== 7'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctl got %b want %b", obs_ctl(), 7'b0);
        end
        tests_run++;
        if ({A_Rsp_Read_Data, B_Rsp_Read_Data, Mem_Address, Mem_Write_Data} !== 128'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data got %h %h %h %h want all 0",
                     A_Rsp_Read_Data, B_Rsp_Read_Data, Mem_Address, Mem_Write_Data);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_write_read();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
                1:       drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
                default: drive(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            model_eval();
            #1;
            tests_run++;
            if (obs_ctl() !== exp_ctl()) begin
                tests_failed++;
                $display("[TB] FAIL wr_rd_ctl cyc%0d got %b want %b", i, obs_ctl(), exp_ctl());
            end
            tests_run++;
            if ({A_Rsp_Read_Data, B_Rsp_Read_Data, Mem_Address, Mem_Write_Data} !==
                {exp_a_rd, exp_b_rd, exp_maddr, exp_mwd}) begin
                tests_failed++;
                $display("[TB] FAIL wr_rd_data cyc%0d got %h %h %h %h want %h %h %h %h", i,
                         A_Rsp_Read_Data, B_Rsp_Read_Data, Mem_Address, Mem_Write_Data,
                         exp_a_rd, exp_b_rd, exp_maddr, exp_mwd);
            end
            if (i == 2) begin
                tests_run++;
                if (A_Rsp_Read_Data !== 32'hDEADBEEF) begin
                    tests_failed++;
                    $display("[TB] FAIL wr_rd_readback got %h want deadbeef", A_Rsp_Read_Data);
                end
            end
            model_commit();
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) drive(1, 0, 32'(i * 8), 0, 1, 0, 32'(i * 8 + 4), 0);
            else       drive(0, 0, 0, 0, 0, 0, 0, 0);
            model_eval();
            #1;
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
            if (i < 6) begin
                tests_run++;
                if ({A_Req_Ready, B_Req_Ready} !== want) begin
                    tests_failed++;
                    $display("[TB] FAIL contention_grant cyc%0d got %b want %b", i,
                             {A_Req_Ready, B_Req_Ready}, want);
                end
            end
            tests_run++;
            if (obs_ctl() !== exp_ctl() ||
                {A_Rsp_Read_Data, B_Rsp_Read_Data} !== {exp_a_rd, exp_b_rd}) begin
                tests_failed++;
                $display("[TB] FAIL contention_rsp cyc%0d got %b %h %h want %b %h %h", i,
                         obs_ctl(), A_Rsp_Read_Data, B_Rsp_Read_Data, exp_ctl(), exp_a_rd, exp_b_rd);
            end
            model_commit();
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h55);
                1:       drive(0, 0, 0, 0, 1, 0, 32'h20, 32'h0);
                default: drive(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            model_eval();
            #1;
            tests_run++;
            if (obs_ctl() !== exp_ctl() ||
                {B_Rsp_Read_Data, Mem_Address, Mem_Write_Data} !== {exp_b_rd, exp_maddr, exp_mwd}) begin
                tests_failed++;
                $display("[TB] FAIL b2b cyc%0d got %b %h %h %h want %b %h %h %h", i, obs_ctl(),
                         B_Rsp_Read_Data, Mem_Address, Mem_Write_Data, exp_ctl(), exp_b_rd, exp_maddr, exp_mwd);
            end
            if (i == 2) begin
                tests_run++;
                if (B_Rsp_Valid !== 1'b1 || B_Rsp_Read_Data !== 32'h55) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_readback got v=%b %h want v=1 00000055", B_Rsp_Valid, B_Rsp_Read_Data);
                end
            end
            model_commit();
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] prior;
        do_reset();
        prior = model_mem[16];
        drive(1, 1, 32'h40, 32'h1234, 0, 0, 0, 0);
        model_eval();
        #1;
        tests_run++;
        if (A_Req_Ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midop_accept got %b want 1", A_Req_Ready);
        end
        model_commit();
        @(posedge Clk);
        #1;
        // Write is now in flight; kill it before the edge that would commit it.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        Reset_n = 1'b0;
        #1;
        tests_run++;
        if ({Mem_Write, A_Rsp_Valid, B_Rsp_Valid} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL midop_drop got wr=%b av=%b bv=%b want 000", Mem_Write, A_Rsp_Valid, B_Rsp_Valid);
        end
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive(1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
                1:       drive(0, 0, 0, 0, 1, 0, 32'h44, 0);
                default: drive(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            model_eval();
            #1;
            if (i == 0) begin
                tests_run++;
                if ({A_Req_Ready, B_Req_Ready} !== 2'b10) begin
                    tests_failed++;
                    $display("[TB] FAIL midop_tie got %b want 10", {A_Req_Ready, B_Req_Ready});
                end
            end
            if (i == 1) begin
                tests_run++;
                if (A_Rsp_Read_Data !== prior) begin
                    tests_failed++;
                    $display("[TB] FAIL midop_prior got %h want %h", A_Rsp_Read_Data, prior);
                end
            end
            tests_run++;
            if (obs_ctl() !== exp_ctl() ||
                {A_Rsp_Read_Data, B_Rsp_Read_Data} !== {exp_a_rd, exp_b_rd}) begin
                tests_failed++;
                $display("[TB] FAIL midop_rsp cyc%0d got %b %h %h want %b %h %h", i, obs_ctl(),
                         A_Rsp_Read_Data, B_Rsp_Read_Data, exp_ctl(), exp_a_rd, exp_b_rd);
            end
            model_commit();
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_addr_check();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(1, 1, 32'h1002, 32'hCAFEF00D, 0, 0, 0, 0);
                1:       drive(1, 0, 32'h1000, 32'h0, 0, 0, 0, 0);
                default: drive(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            model_eval();
            #1;
`ifdef DMEM_ARB_ADDR_CHECK_EN
            if (i == 1 || i == 2) begin
                tests_run++;
                if ({Mem_Write, A_Rsp_Valid, A_Rsp_Error} !== 3'b011 || A_Rsp_Read_Data !== 32'h0) begin
                    tests_failed++;
                    $display("[TB] FAIL addr_err cyc%0d got wr=%b v=%b e=%b d=%h want wr=0 v=1 e=1 d=0",
                             i, Mem_Write, A_Rsp_Valid, A_Rsp_Error, A_Rsp_Read_Data);
                end
            end
`else
            if (i == 1) begin
                tests_run++;
                if ({Mem_Write, A_Rsp_Error} !== 2'b10 || Mem_Address !== 32'h1002) begin
                    tests_failed++;
                    $display("[TB] FAIL addr_pass got wr=%b e=%b addr=%h want wr=1 e=0 addr=00001002",
                             Mem_Write, A_Rsp_Error, Mem_Address);
                end
            end
`endif
            tests_run++;
            if (obs_ctl() !== exp_ctl() ||
                {A_Rsp_Read_Data, Mem_Address, Mem_Write_Data} !== {exp_a_rd, exp_maddr, exp_mwd}) begin
                tests_failed++;
                $display("[TB] FAIL addr_model cyc%0d got %b %h %h %h want %b %h %h %h", i, obs_ctl(),
                         A_Rsp_Read_Data, Mem_Address, Mem_Write_Data, exp_ctl(), exp_a_rd, exp_maddr, exp_mwd);
            end
            model_commit();
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_random();
        bit          a_v = 0, b_v = 0, a_w = 0, b_w = 0;
        logic [31:0] a_a = 0, b_a = 0, a_d = 0, b_d = 0;
        do_reset();
        for (int i = 0; i < 304; i++) begin
            // A request that was not granted stays on the bus unchanged.
            if (!a_v || exp_a_ready) begin
                a_v = (i < 300) && ($urandom_range(0, 9) < 7);
                a_w = $urandom_range(0, 1) == 1;
                a_a = 32'($urandom_range(0, 31)) << 2;
                a_d = $urandom;
            end
            if (!b_v || exp_b_ready) begin
                b_v = (i < 300) && ($urandom_range(0, 9) < 6);
                b_w = $urandom_range(0, 1) == 1;
                b_a = 32'($urandom_range(0, 31)) << 2;
                b_d = $urandom;
            end
            drive(a_v, a_w, a_a, a_d, b_v, b_w, b_a, b_d);
            model_eval();
            #1;
            tests_run++;
            if (obs_ctl() !== exp_ctl() ||
                {A_Rsp_Read_Data, B_Rsp_Read_Data, Mem_Address, Mem_Write_Data} !==
                {exp_a_rd, exp_b_rd, exp_maddr, exp_mwd}) begin
                tests_failed++;
                $display("[TB] FAIL random cyc%0d got %b %h %h %h %h want %b %h %h %h %h", i, obs_ctl(),
                         A_Rsp_Read_Data, B_Rsp_Read_Data, Mem_Address, Mem_Write_Data,
                         exp_ctl(), exp_a_rd, exp_b_rd, exp_maddr, exp_mwd);
            end
            model_commit();
            @(posedge Clk);
            #1;
        end
    endtask

    // ---------------- sequence ----------------------------------------------
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = init_word(i);
        exp_a_ready = 0;
        exp_b_ready = 0;
        model_reset();
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_reset_midop();
        test_addr_check();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
